// File: rtl/mem_access_seq_pkg.sv
// Shared types and constants for the multicycle memory-access sequencer.
package mem_access_seq_pkg;

    localparam int unsigned MEM_LATENCY_DEF = 2;

    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/mem_access_seq_if.sv
// Request/response and data-memory signals of the sequencer, bundled as one interface.
interface mem_access_seq_if;

    logic        req;
    logic        op_store;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] mdr;
    logic [31:0] load_data;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Sequencer side.
    modport slave (
        input  req, op_store, size, sext, addr, wdata, mem_rdata,
        output busy, done, err, mdr, load_data, mem_addr, mem_wr, mem_wdata
    );

    // Control unit and memory side.
    modport master (
        output req, op_store, size, sext, addr, wdata, mem_rdata,
        input  busy, done, err, mdr, load_data, mem_addr, mem_wr, mem_wdata
    );

endinterface

// File: rtl/mem_access_seq_lane_mux.sv
// Little-endian lane extraction for loads and lane merge for sub-word stores.
module mem_access_seq_lane_mux
    import mem_access_seq_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        sext_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] ld_val_o,
    output logic [31:0] st_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = word_i[{lane_i, 3'b000} +: 8];
        half_sel  = word_i[{lane_i[1], 4'b0000} +: 16];
        ld_val_o  = word_i;
        st_word_o = st_data_i;
        case (size_i)
            SZ_BYTE: begin
                ld_val_o  = {{24{sext_i & byte_sel[7]}}, byte_sel};
                st_word_o = word_i;
                st_word_o[{lane_i, 3'b000} +: 8] = st_data_i[7:0];
            end
            SZ_HALF: begin
                ld_val_o  = {{16{sext_i & half_sel[15]}}, half_sel};
                st_word_o = word_i;
                st_word_o[{lane_i[1], 4'b0000} +: 16] = st_data_i[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_seq.sv
// Multicycle load/store sequencer: one access per request, read-modify-write for sub-word
// stores so that memory only ever receives full-word writes.
module mem_access_seq
    import mem_access_seq_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int unsigned CNT_W       = 2
) (
    input  logic             clock,
    input  logic             reset,
    mem_access_seq_if.slave  bus
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MEM_LATENCY - 1);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            op_store_q, op_store_d;
    logic [1:0]      size_q, size_d;
    logic            sext_q, sext_d;
    logic [1:0]      lane_q, lane_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     mdr_q, mdr_d;
    logic [31:0]     load_data_q, load_data_d;
    logic [31:0]     mem_addr_q, mem_addr_d;

    logic [31:0]     mux_word;
    logic [31:0]     ld_val;
    logic [31:0]     st_word;
    logic            bad_req;

    // Loads extract from the incoming read word; stores merge into the captured MDR.
    assign mux_word = (state_q == StWr) ? mdr_q : bus.mem_rdata;

    mem_access_seq_lane_mux u_lane_mux (
        .word_i    (mux_word),
        .lane_i    (lane_q),
        .size_i    (size_q),
        .sext_i    (sext_q),
        .st_data_i (wdata_q),
        .ld_val_o  (ld_val),
        .st_word_o (st_word)
    );

    always_comb begin
        bad_req = (bus.size == 2'b00)
                | ((bus.size == SZ_HALF) & bus.addr[0])
                | ((bus.size == SZ_WORD) & (bus.addr[1:0] != 2'b00));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_store_d  = op_store_q;
        size_d      = size_q;
        sext_d      = sext_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        mdr_d       = mdr_q;
        load_data_d = load_data_q;
        mem_addr_d  = mem_addr_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    op_store_d = bus.op_store;
                    size_d     = bus.size;
                    sext_d     = bus.sext;
                    lane_d     = bus.addr[1:0];
                    wdata_d    = bus.wdata;
                    if (bad_req) begin
                        state_d = StErr;
                    end else begin
                        mem_addr_d = {bus.addr[31:2], 2'b00};
                        cnt_d      = '0;
                        state_d    = (bus.op_store && bus.size == SZ_WORD) ? StWr : StRd;
                    end
                end
            end
            StRd: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
                    mdr_d = bus.mem_rdata;
                    if (op_store_q) begin
                        state_d = StWr;
                    end else begin
                        load_data_d = ld_val;
                        state_d     = StDone;
                    end
                end
            end
            StWr:    state_d = StDone;
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_store_q  <= 1'b0;
            size_q      <= 2'b00;
            sext_q      <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= '0;
            mdr_q       <= '0;
            load_data_q <= '0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_store_q  <= op_store_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            mdr_q       <= mdr_d;
            load_data_q <= load_data_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    always_comb begin
        bus.busy      = (state_q != StIdle);
        bus.done      = (state_q == StDone) || (state_q == StErr);
        bus.err       = (state_q == StErr);
        bus.mdr       = mdr_q;
        bus.load_data = load_data_q;
        bus.mem_addr  = mem_addr_q;
        bus.mem_wr    = (state_q == StWr);
        bus.mem_wdata = (state_q == StWr) ? st_word : 32'h0;
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Scoreboard bench for mem_access_seq with a one-word latency-2 memory model.
module tb_mem_access_seq;

    typedef struct {
        logic        err;
        logic [31:0] mdr;
        logic [31:0] ld;
        logic [31:0] mem;
        int          done_cyc;
        int          wr_exp;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc;
    int   wr_total;
    int   age;
    int   n_pass;
    int   n_total;
    logic [31:0] mem_word = 32'h8899AABB;
    exp_t q[$];
    exp_t mon_e;

    mem_access_seq_if bus ();

    mem_access_seq #(
        .MEM_LATENCY (2),
        .CNT_W       (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Read data becomes valid only in the second read cycle at the addressed word.
    assign bus.mem_rdata = (age >= 1 && bus.mem_addr == 32'h1000) ? mem_word : 32'h5A5A5A5A;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.busy && !bus.mem_wr && !bus.done) age <= age + 1;
        else age <= 0;
        if (bus.mem_wr) begin
            wr_total <= wr_total + 1;
            if (bus.mem_addr == 32'h1000) mem_word <= bus.mem_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(negedge clock) begin
        if (reset && bus.done) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL spurious_done: done at cycle %0d with nothing pending", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("err", 32'(bus.err), 32'(mon_e.err));
                chk("mdr", bus.mdr, mon_e.mdr);
                chk("load_data", bus.load_data, mon_e.ld);
                chk("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
                chk("write_count", 32'(wr_total), 32'(mon_e.wr_exp));
                chk("mem_word", mem_word, mon_e.mem);
                chk("mem_addr", bus.mem_addr, 32'h1000);
            end
        end
    end

    task automatic start_req(input logic st, input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic e_err, input logic [31:0] e_mdr,
                             input logic [31:0] e_ld, input logic [31:0] e_mem,
                             input int lat, input int wr_inc);
        exp_t e;
        @(negedge clock);
        bus.req      = 1'b1;
        bus.op_store = st;
        bus.size     = sz;
        bus.sext     = sx;
        bus.addr     = a;
        bus.wdata    = wd;
        e.err      = e_err;
        e.mdr      = e_mdr;
        e.ld       = e_ld;
        e.mem      = e_mem;
        e.done_cyc = cyc + lat;
        e.wr_exp   = wr_total + wr_inc;
        q.push_back(e);
        @(posedge clock);
        #1 bus.req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            if (q.size() == 0) break;
            @(negedge clock);
        end
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL timeout: %0d responses still pending", q.size());
            q.delete();
        end
        @(negedge clock);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
        chk({tag, "_done"}, 32'(bus.done), 32'h0);
        chk({tag, "_err"}, 32'(bus.err), 32'h0);
        chk({tag, "_mdr"}, bus.mdr, 32'h0);
        chk({tag, "_load_data"}, bus.load_data, 32'h0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
        chk({tag, "_mem_wr"}, 32'(bus.mem_wr), 32'h0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    endtask

    task automatic run(input logic st, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_mdr,
                       input logic [31:0] e_ld, input logic [31:0] e_mem,
                       input int lat, input int wr_inc);
        start_req(st, sz, sx, a, wd, e_err, e_mdr, e_ld, e_mem, lat, wr_inc);
        wait_idle();
    endtask

    initial begin
        int wr_saved;
        n_pass = 0;
        n_total = 0;
        cyc = 0;
        wr_total = 0;
        age = 0;
        reset = 1'b0;
        bus.req = 1'b0;
        bus.op_store = 1'b0;
        bus.size = 2'b00;
        bus.sext = 1'b0;
        bus.addr = 32'h0;
        bus.wdata = 32'h0;
        repeat (2) @(negedge clock);
        chk_all_zero("reset");
        reset = 1'b1;
        @(negedge clock);

        //  st    size   sx   addr          wdata         err   mdr           ld            mem          lat wr
        run(1'b0, 2'b01, 1'b1, 32'h00001002, 32'h0,        1'b0, 32'h8899AABB, 32'hFFFFFF99, 32'h8899AABB, 3, 0);
        run(1'b0, 2'b10, 1'b0, 32'h00001002, 32'h0,        1'b0, 32'h8899AABB, 32'h00008899, 32'h8899AABB, 3, 0);
        run(1'b1, 2'b01, 1'b0, 32'h00001001, 32'h123456CC, 1'b0, 32'h8899AABB, 32'h00008899, 32'h8899CCBB, 4, 1);
        run(1'b1, 2'b11, 1'b0, 32'h00001000, 32'hDEADBEEF, 1'b0, 32'h8899AABB, 32'h00008899, 32'hDEADBEEF, 2, 1);
        run(1'b0, 2'b10, 1'b0, 32'h00001003, 32'h0,        1'b1, 32'h8899AABB, 32'h00008899, 32'hDEADBEEF, 1, 0);
        run(1'b0, 2'b00, 1'b0, 32'h00001000, 32'h0,        1'b1, 32'h8899AABB, 32'h00008899, 32'hDEADBEEF, 1, 0);
        run(1'b1, 2'b11, 1'b0, 32'h00001002, 32'h11111111, 1'b1, 32'h8899AABB, 32'h00008899, 32'hDEADBEEF, 1, 0);
        run(1'b0, 2'b10, 1'b1, 32'h00001000, 32'h0,        1'b0, 32'hDEADBEEF, 32'hFFFFBEEF, 32'hDEADBEEF, 3, 0);
        run(1'b0, 2'b01, 1'b0, 32'h00001003, 32'h0,        1'b0, 32'hDEADBEEF, 32'h000000DE, 32'hDEADBEEF, 3, 0);
        run(1'b1, 2'b10, 1'b0, 32'h00001002, 32'hAAAA1234, 1'b0, 32'hDEADBEEF, 32'h000000DE, 32'h1234BEEF, 4, 1);

        // Word load with req re-asserted (as a word store) through RD and DONE.
        start_req(1'b0, 2'b11, 1'b1, 32'h00001000, 32'h0,
                  1'b0, 32'h1234BEEF, 32'h1234BEEF, 32'h1234BEEF, 3, 0);
        @(negedge clock);
        bus.req = 1'b1;
        bus.op_store = 1'b1;
        bus.size = 2'b11;
        bus.wdata = 32'h0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) break;
            @(negedge clock);
        end
        bus.req = 1'b0;
        repeat (4) @(negedge clock);
        chk("ignored_req_busy", 32'(bus.busy), 32'h0);
        chk("ignored_req_queue", 32'(q.size()), 32'h0);
        chk("ignored_req_mem", mem_word, 32'h1234BEEF);
        q.delete();

        // Reset in the first RD cycle of a byte store.
        wr_saved = wr_total;
        @(negedge clock);
        bus.req = 1'b1;
        bus.op_store = 1'b1;
        bus.size = 2'b01;
        bus.sext = 1'b0;
        bus.addr = 32'h00001000;
        bus.wdata = 32'h000000FF;
        @(posedge clock);
        #1 bus.req = 1'b0;
        #2 reset = 1'b0;
        #1 chk_all_zero("midreset");
        repeat (4) @(negedge clock);
        chk("midreset_writes", 32'(wr_total), 32'(wr_saved));
        chk("midreset_mem", mem_word, 32'h1234BEEF);
        reset = 1'b1;
        @(negedge clock);

        run(1'b0, 2'b01, 1'b1, 32'h00001001, 32'h0, 1'b0, 32'h1234BEEF, 32'hFFFFFFBE, 32'h1234BEEF, 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
